// File: rtl/hwag_pkg.sv
// rtl/hwag_pkg.sv - shared constants and FSM state type for the crank signal generator
// Contents:
//   PCNT_WIDTH      default width of the tooth-period / pitch-counter datapath
//   PERIOD_MIN/MAX  receiver-valid window for a written tooth period, in clk cycles
//   crank_state_t   generator FSM states
package hwag_pkg;

    localparam int PCNT_WIDTH = 24;

    // 5592405 * 3 = 24'hFFFFFF, so three pitches always fit in the counter width.
    localparam int PERIOD_MIN = 512;
    localparam int PERIOD_MAX = 5592405;

    typedef enum logic [1:0] {
        IDLE,
        TOOTH_HI,
        TOOTH_LO,
        GAP
    } crank_state_t;

endpackage

// File: rtl/counter_compare.sv
// rtl/counter_compare.sv - free-running up counter with synchronous clear and terminal compare
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset, clears count
//   srst   in   synchronous clear; count is 0 on the next cycle
//   dtop   in   terminal value compared against count
//   count  out  current count
//   hit    out  count == dtop
module counter_compare #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             srst,
    input  logic [WIDTH-1:0] dtop,
    output logic [WIDTH-1:0] count,
    output logic             hit
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (srst) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign hit = (count == dtop);

endmodule

// File: rtl/crank_signal_gen.sv
// rtl/crank_signal_gen.sv - synthetic missing-tooth crank trigger-wheel signal generator
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   ena         in   generator run enable; low returns to IDLE next cycle
//   period      in   requested tooth pitch in clk cycles
//   period_wr   in   strobe capturing period into the staging register
//   crank_out   out  trigger-wheel signal, high during the first half of each real tooth
//   tooth_num   out  current pitch index 0..TEETH_TOTAL-1
//   gap_active  out  high during the missing-tooth pitches
//   rev_strobe  out  one-cycle pulse on the first cycle of tooth 0
//   period_err  out  one-cycle pulse after a rejected period write
module crank_signal_gen
    import hwag_pkg::*;
#(
    parameter int                    PCNT_WIDTH    = hwag_pkg::PCNT_WIDTH,
    parameter int                    TEETH_TOTAL   = 60,
    parameter int                    TEETH_MISSING = 2,
    parameter logic [PCNT_WIDTH-1:0] DEF_PERIOD    = PCNT_WIDTH'(24'd4000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PCNT_WIDTH-1:0] period,
    input  logic                  period_wr,
    output logic                  crank_out,
    output logic [7:0]            tooth_num,
    output logic                  gap_active,
    output logic                  rev_strobe,
    output logic                  period_err
);

    localparam logic [7:0]            LAST_TOOTH = 8'(TEETH_TOTAL - 1);
    localparam logic [7:0]            LAST_REAL  = 8'(TEETH_TOTAL - TEETH_MISSING - 1);
    localparam logic [PCNT_WIDTH-1:0] P_MIN      = PCNT_WIDTH'(PERIOD_MIN);
    localparam logic [PCNT_WIDTH-1:0] P_MAX      = PCNT_WIDTH'(PERIOD_MAX);

    crank_state_t          state;
    crank_state_t          state_nxt;
    logic [PCNT_WIDTH-1:0] staging;
    logic [PCNT_WIDTH-1:0] active;
    logic [PCNT_WIDTH-1:0] pcnt;
    logic [PCNT_WIDTH-1:0] dtop;
    logic [PCNT_WIDTH-1:0] half_m1;
    logic                  pitch_end;
    logic                  hi_end;
    logic                  cnt_srst;
    logic                  period_ok;
    logic                  load_active;
    logic                  rev_nxt;
    logic [7:0]            tooth_nxt;

    assign dtop      = active - PCNT_WIDTH'(1);
    assign half_m1   = (active >> 1) - PCNT_WIDTH'(1);
    assign hi_end    = (pcnt == half_m1);
    assign period_ok = (period >= P_MIN) && (period <= P_MAX);

    // Held at 0 while idle or disabled so the first TOOTH_HI cycle sees pcnt=0.
    assign cnt_srst  = (state == IDLE) || !ena || pitch_end;

    counter_compare #(
        .WIDTH(PCNT_WIDTH)
    ) u_pcnt (
        .clk  (clk),
        .rst  (rst),
        .srst (cnt_srst),
        .dtop (dtop),
        .count(pcnt),
        .hit  (pitch_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tooth_nxt   = tooth_num;
        rev_nxt     = 1'b0;
        load_active = 1'b0;
        if (!ena) begin
            state_nxt = IDLE;
            tooth_nxt = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt   = TOOTH_HI;
                    tooth_nxt   = 8'd0;
                    rev_nxt     = 1'b1;
                    load_active = 1'b1;
                end
                TOOTH_HI: begin
                    if (hi_end) begin
                        state_nxt = TOOTH_LO;
                    end
                end
                TOOTH_LO: begin
                    if (pitch_end) begin
                        if (tooth_num != LAST_REAL) begin
                            state_nxt = TOOTH_HI;
                            tooth_nxt = tooth_num + 8'd1;
                        end else if (TEETH_MISSING == 0) begin
                            state_nxt   = TOOTH_HI;
                            tooth_nxt   = 8'd0;
                            rev_nxt     = 1'b1;
                            load_active = 1'b1;
                        end else begin
                            state_nxt = GAP;
                            tooth_nxt = tooth_num + 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (pitch_end) begin
                        if (tooth_num == LAST_TOOTH) begin
                            state_nxt   = TOOTH_HI;
                            tooth_nxt   = 8'd0;
                            rev_nxt     = 1'b1;
                            load_active = 1'b1;
                        end else begin
                            tooth_nxt = tooth_num + 8'd1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tooth_nxt = 8'd0;
                end
            endcase
        end
    end

    // Outputs are flops fed from the next-state decode so they line up with state.
    // A period write on the tooth-0 entry cycle lands in staging after active has
    // sampled the old staging value, so it applies from the following revolution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crank_out  <= 1'b0;
            tooth_num  <= 8'd0;
            gap_active <= 1'b0;
            rev_strobe <= 1'b0;
            period_err <= 1'b0;
            staging    <= DEF_PERIOD;
            active     <= DEF_PERIOD;
        end else begin
            crank_out  <= (state_nxt == TOOTH_HI);
            tooth_num  <= tooth_nxt;
            gap_active <= (state_nxt == GAP);
            rev_strobe <= rev_nxt;
            period_err <= period_wr && !period_ok;
            if (period_wr && period_ok) begin
                staging <= period;
            end
            if (load_active) begin
                active <= staging;
            end
        end
    end

endmodule

// File: tb/tb_crank_signal_gen.sv
// tb/tb_crank_signal_gen.sv - directed self-checking bench for crank_signal_gen
module tb_crank_signal_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [23:0] period;
    logic        period_wr;
    logic        crank_out;
    logic [7:0]  tooth_num;
    logic        gap_active;
    logic        rev_strobe;
    logic        period_err;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crank_signal_gen dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .period    (period),
        .period_wr (period_wr),
        .crank_out (crank_out),
        .tooth_num (tooth_num),
        .gap_active(gap_active),
        .rev_strobe(rev_strobe),
        .period_err(period_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic write_period(input logic [23:0] v, input logic exp_err, input string tag);
        period    = v;
        period_wr = 1'b1;
        tick();
        period_wr = 1'b0;
        check({tag, "_err"}, period_err, exp_err);
        tick();
        check({tag, "_clr"}, period_err, 1'b0);
    endtask

    task automatic count_level(input logic lvl, input int limit, output int n);
        n = 0;
        while (crank_out === lvl && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_rise(input logic [7:0] t, input int limit, input string tag);
        int n;
        n = 0;
        while (!(tooth_num === t && crank_out === 1'b1) && n < limit) begin
            n++;
            tick();
        end
        check(tag, n < limit, 1'b1);
    endtask

    initial begin
        int n;
        int g;
        int ns;
        int c0;
        int seq[8];

        rst       = 1'b1;
        ena       = 1'b0;
        period_wr = 1'b0;
        period    = 24'd0;
        tick();
        tick();
        check("rst_crank", crank_out, 1'b0);
        check("rst_tooth", tooth_num, 8'd0);
        check("rst_gap", gap_active, 1'b0);
        check("rst_rev", rev_strobe, 1'b0);
        check("rst_err", period_err, 1'b0);
        rst = 1'b0;
        tick();

        // Window boundaries while idle; final staging value is 1001.
        write_period(24'd511, 1'b1, "wr_511");
        write_period(24'd5592406, 1'b1, "wr_5592406");
        write_period(24'd512, 1'b0, "wr_512");
        write_period(24'd5592405, 1'b0, "wr_5592405");
        write_period(24'd1001, 1'b0, "wr_1001");

        // Odd period 1001: high 500, low 501.
        ena = 1'b1;
        tick();
        check("odd_rise", crank_out, 1'b1);
        check("odd_rev", rev_strobe, 1'b1);
        check("odd_tooth0", tooth_num, 8'd0);
        count_level(1'b1, 5000, n);
        check("odd_hi", n, 500);
        count_level(1'b0, 5000, n);
        check("odd_lo", n, 501);
        check("odd_tooth1", tooth_num, 8'd1);
        check("odd_rev_mid", rev_strobe, 1'b0);

        // Disable during TOOTH_HI, then re-enable: staging kept.
        ena = 1'b0;
        tick();
        check("dis_crank", crank_out, 1'b0);
        check("dis_tooth", tooth_num, 8'd0);
        check("dis_gap", gap_active, 1'b0);
        ena = 1'b1;
        tick();
        check("reen_rev", rev_strobe, 1'b1);
        check("reen_tooth", tooth_num, 8'd0);
        count_level(1'b1, 5000, n);
        check("retain_hi", n, 500);

        // Reset restores the 4000 default.
        ena = 1'b0;
        rst = 1'b1;
        tick();
        check("rst2_crank", crank_out, 1'b0);
        rst = 1'b0;
        tick();
        ena = 1'b1;
        tick();
        check("def_rise", crank_out, 1'b1);
        check("def_rev", rev_strobe, 1'b1);
        count_level(1'b1, 10000, n);
        check("def_hi", n, 2000);
        count_level(1'b0, 10000, n);
        check("def_lo", n, 2000);
        check("def_tooth1", tooth_num, 8'd1);
        write_period(24'd1000, 1'b0, "wr_1000");
        ena = 1'b0;
        tick();
        check("dis2_crank", crank_out, 1'b0);

        // Revolution at 1000; write 512 plus two rejected values at tooth 10.
        ena = 1'b1;
        tick();
        check("r0_rev", rev_strobe, 1'b1);
        check("r0_crank", crank_out, 1'b1);
        c0 = cyc;
        wait_rise(8'd10, 20000, "reach_t10");
        write_period(24'd100, 1'b1, "wr_100");
        write_period(24'hFFFFFF, 1'b1, "wr_ffffff");
        write_period(24'd512, 1'b0, "wr_512_mid");
        wait_rise(8'd11, 3000, "reach_t11");
        count_level(1'b1, 5000, n);
        check("t11_hi", n, 500);
        count_level(1'b0, 5000, n);
        check("t11_lo", n, 500);

        wait_rise(8'd57, 60000, "reach_t57");
        count_level(1'b1, 5000, n);
        check("t57_hi", n, 500);
        for (int i = 0; i < 8; i++) seq[i] = 255;
        seq[0] = int'(tooth_num);
        ns = 1;
        n = 0;
        g = 0;
        while (crank_out === 1'b0 && n < 5000) begin
            if (gap_active === 1'b1) g++;
            if (int'(tooth_num) != seq[ns-1] && ns < 8) begin
                seq[ns] = int'(tooth_num);
                ns++;
            end
            n++;
            tick();
        end
        if (int'(tooth_num) != seq[ns-1] && ns < 8) begin
            seq[ns] = int'(tooth_num);
            ns++;
        end
        check("gap_fall_to_rise", n, 2500);
        check("gap_len", g, 2000);
        check("seq_len", ns, 4);
        check("seq0", seq[0], 57);
        check("seq1", seq[1], 58);
        check("seq2", seq[2], 59);
        check("seq3", seq[3], 0);
        check("r1_rev", rev_strobe, 1'b1);
        check("r1_gap_off", gap_active, 1'b0);
        check("rev_len_1000", cyc - c0, 60000);

        // Next revolution picks up 512.
        count_level(1'b1, 5000, n);
        check("r1_hi", n, 256);
        count_level(1'b0, 5000, n);
        check("r1_lo", n, 256);

        // Asynchronous reset in the middle of the gap.
        n = 0;
        while (gap_active !== 1'b1 && n < 40000) begin
            n++;
            tick();
        end
        check("reach_gap", n < 40000, 1'b1);
        repeat (100) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_gap", gap_active, 1'b0);
        check("arst_crank", crank_out, 1'b0);
        check("arst_tooth", tooth_num, 8'd0);
        check("arst_rev", rev_strobe, 1'b0);
        tick();
        check("arst_hold", crank_out, 1'b0);
        rst = 1'b0;
        ena = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
